// File: rtl/mem_pkg.sv
// mem_pkg: shared constants and types for the burst memory master.
//   AW_DEF / DW_DEF : default address and data widths
//   LEN_W           : width of the burst length field (0 encodes 16)
//   CNT_W           : width of the remaining-beat counter (must hold 16)
//   state_t         : burst FSM state encoding
//   len_to_cnt()    : maps a length field to a beat count
package mem_pkg;

  localparam int AW_DEF = 9;
  localparam int DW_DEF = 16;
  localparam int LEN_W  = 4;
  localparam int CNT_W  = LEN_W + 1;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_RD      = 3'd1,
    ST_RD_TAIL = 3'd2,
    ST_WR      = 3'd3,
    ST_WR_DONE = 3'd4
  } state_t;

  // A zero length field means a full 16-beat burst.
  function automatic logic [CNT_W-1:0] len_to_cnt(input logic [LEN_W-1:0] len);
    return (len == '0) ? CNT_W'(1 << LEN_W) : {1'b0, len};
  endfunction

endpackage

// File: rtl/burst_addr_counter.sv
// burst_addr_counter: address pointer and remaining-beat counter for one burst.
//   clk, rst_b   : clock, synchronous active-low reset
//   i_load       : capture i_load_addr / i_load_len (length 0 means 16)
//   i_load_addr  : burst start address
//   i_load_len   : burst length field
//   i_inc        : one beat consumed: address +1 (wraps mod 2^AW), count -1
//   o_addr_q     : current beat address
//   o_last       : current beat is the final one of the burst
module burst_addr_counter
  import mem_pkg::*;
#(
  parameter int AW = AW_DEF
) (
  input  logic             clk,
  input  logic             rst_b,
  input  logic             i_load,
  input  logic [AW-1:0]    i_load_addr,
  input  logic [LEN_W-1:0] i_load_len,
  input  logic             i_inc,
  output logic [AW-1:0]    o_addr_q,
  output logic             o_last
);

  logic [AW-1:0]    r_addr_q;
  logic [CNT_W-1:0] r_cnt_q;

  always_ff @(posedge clk) begin
    if (!rst_b) begin
      r_addr_q <= '0;
      r_cnt_q  <= '0;
    end else if (i_load) begin
      r_addr_q <= i_load_addr;
      r_cnt_q  <= len_to_cnt(i_load_len);
    end else if (i_inc) begin
      // Natural overflow of the AW-bit register gives the modulo wrap.
      r_addr_q <= r_addr_q + AW'(1);
      r_cnt_q  <= r_cnt_q - CNT_W'(1);
    end
  end

  assign o_addr_q = r_addr_q;
  assign o_last   = (r_cnt_q == CNT_W'(1));

endmodule

// File: rtl/mem_burst_master.sv
// mem_burst_master: issues read or write bursts of 1..16 words to a memory
// with a one-cycle synchronous read port.
//   clk, rst_b            : clock, synchronous active-low reset
//   req_valid/req_ready   : command handshake; req_we selects write (1) / read (0)
//   req_addr, req_len     : start address, length (0 encodes 16)
//   wr_valid/wr_ready     : write-beat handshake carrying wr_data
//   rd_valid, rd_data     : read beats, one cycle after each memory read
//   done                  : one-cycle pulse at burst completion
//   mem_read/mem_write    : memory strobes with mem_addr / mem_din; mem_dout returns
//
// state      | meaning
// -----------+-----------------------------------------------
// ST_IDLE    | waiting for a command, req_ready high
// ST_RD      | issuing one memory read per cycle
// ST_RD_TAIL | last read data returning, done pulses
// ST_WR      | forwarding write beats as they arrive
// ST_WR_DONE | all beats written, done pulses
module mem_burst_master
  import mem_pkg::*;
#(
  parameter int AW = AW_DEF,
  parameter int DW = DW_DEF
) (
  input  logic             clk,
  input  logic             rst_b,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic             req_we,
  input  logic [AW-1:0]    req_addr,
  input  logic [LEN_W-1:0] req_len,
  input  logic             wr_valid,
  output logic             wr_ready,
  input  logic [DW-1:0]    wr_data,
  output logic             rd_valid,
  output logic [DW-1:0]    rd_data,
  output logic             done,
  output logic             mem_write,
  output logic             mem_read,
  output logic [AW-1:0]    mem_addr,
  output logic [DW-1:0]    mem_din,
  input  logic [DW-1:0]    mem_dout
);

  state_t        r_state;
  state_t        w_state_n;
  logic          w_load;
  logic          w_inc;
  logic [AW-1:0] w_addr_q;
  logic          w_last;
  logic          w_mem_read;
  logic          w_mem_write;
  logic          r_rd_valid;

  burst_addr_counter #(.AW(AW)) u_cnt (
    .clk         (clk),
    .rst_b       (rst_b),
    .i_load      (w_load),
    .i_load_addr (req_addr),
    .i_load_len  (req_len),
    .i_inc       (w_inc),
    .o_addr_q    (w_addr_q),
    .o_last      (w_last)
  );

  always_ff @(posedge clk) begin
    if (!rst_b) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_n;
    end
  end

  always_comb begin
    w_state_n = r_state;
    w_load    = 1'b0;
    w_inc     = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        if (req_valid) begin
          w_load    = 1'b1;
          w_state_n = req_we ? ST_WR : ST_RD;
        end
      end
      ST_RD: begin
        w_inc = 1'b1;
        if (w_last) w_state_n = ST_RD_TAIL;
      end
      ST_RD_TAIL: w_state_n = ST_IDLE;
      ST_WR: begin
        if (wr_valid) begin
          w_inc = 1'b1;
          if (w_last) w_state_n = ST_WR_DONE;
        end
      end
      ST_WR_DONE: w_state_n = ST_IDLE;
      default:    w_state_n = ST_IDLE;
    endcase
  end

  // Handshakes and strobes are gated by rst_b so nothing happens on a reset cycle.
  assign req_ready   = rst_b & (r_state == ST_IDLE);
  assign wr_ready    = rst_b & (r_state == ST_WR);
  assign w_mem_read  = rst_b & (r_state == ST_RD);
  assign w_mem_write = rst_b & (r_state == ST_WR) & wr_valid;

  assign mem_read  = w_mem_read;
  assign mem_write = w_mem_write;
  assign mem_addr  = (w_mem_read | w_mem_write) ? w_addr_q : '0;
  assign mem_din   = w_mem_write ? wr_data : '0;

  // Read data appears one cycle after the strobe, matching the memory latency.
  always_ff @(posedge clk) begin
    if (!rst_b) begin
      r_rd_valid <= 1'b0;
    end else begin
      r_rd_valid <= w_mem_read;
    end
  end

  assign rd_valid = r_rd_valid;
  assign rd_data  = r_rd_valid ? mem_dout : '0;
  assign done     = rst_b & ((r_state == ST_RD_TAIL) | (r_state == ST_WR_DONE));

endmodule

// File: tb/tb_mem_burst_master.sv
module tb_mem_burst_master;

  logic        clk;
  logic        rst_b;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [8:0]  req_addr;
  logic [3:0]  req_len;
  logic        wr_valid;
  logic        wr_ready;
  logic [15:0] wr_data;
  logic        rd_valid;
  logic [15:0] rd_data;
  logic        done;
  logic        mem_write;
  logic        mem_read;
  logic [8:0]  mem_addr;
  logic [15:0] mem_din;
  logic [15:0] mem_dout;

  int checks = 0;
  int errors = 0;

  logic [15:0] mem     [512];
  logic [15:0] ref_mem [512];
  logic        bd_we;
  logic [8:0]  bd_addr;
  logic [15:0] bd_data;

  logic [31:0] wpat;
  logic [15:0] wdat [16];
  int          ncyc;

  mem_burst_master #(.AW(9), .DW(16)) dut (
    .clk       (clk),
    .rst_b     (rst_b),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_we    (req_we),
    .req_addr  (req_addr),
    .req_len   (req_len),
    .wr_valid  (wr_valid),
    .wr_ready  (wr_ready),
    .wr_data   (wr_data),
    .rd_valid  (rd_valid),
    .rd_data   (rd_data),
    .done      (done),
    .mem_write (mem_write),
    .mem_read  (mem_read),
    .mem_addr  (mem_addr),
    .mem_din   (mem_din),
    .mem_dout  (mem_dout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory model: one-cycle synchronous read, plus a backdoor write port.
  always @(posedge clk) begin
    if (mem_write) mem[mem_addr] <= mem_din;
    if (bd_we) mem[bd_addr] <= bd_data;
    if (mem_read) mem_dout <= mem[mem_addr];
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic preload(input logic [8:0] a, input logic [15:0] d);
    bd_we = 1'b1; bd_addr = a; bd_data = d;
    ref_mem[a] = d;
    tick();
    bd_we = 1'b0;
  endtask

  // Starts at posedge+1 of an idle cycle, ends at posedge+1 of the idle cycle after done.
  task automatic read_burst(input logic [8:0] a, input logic [3:0] lf);
    int L;
    int beats;
    logic [8:0] ea;
    logic exp_rd;
    logic exp_v;
    L = (lf == 4'd0) ? 16 : int'(lf);
    beats = 0;
    req_valid = 1'b1; req_we = 1'b0; req_addr = a; req_len = lf;
    #4;
    checks++;
    if (req_ready !== 1'b1) begin errors++; $display("FAIL rd_req_ready: got %b expected 1", req_ready); end
    tick();
    req_valid = 1'b0; req_addr = '0; req_len = '0;
    for (int c = 1; c <= L + 1; c++) begin
      #4;
      exp_rd = (c <= L);
      exp_v  = (c >= 2);
      ea     = a + 9'(c - 1);
      checks++;
      if (mem_read !== exp_rd) begin errors++; $display("FAIL rd_mem_read c=%0d: got %b expected %b", c, mem_read, exp_rd); end
      checks++;
      if (mem_addr !== (exp_rd ? ea : 9'd0)) begin errors++; $display("FAIL rd_mem_addr c=%0d: got %h expected %h", c, mem_addr, (exp_rd ? ea : 9'd0)); end
      checks++;
      if (mem_write !== 1'b0) begin errors++; $display("FAIL rd_mem_write c=%0d: got %b expected 0", c, mem_write); end
      checks++;
      if (rd_valid !== exp_v) begin errors++; $display("FAIL rd_valid c=%0d: got %b expected %b", c, rd_valid, exp_v); end
      if (exp_v) begin
        checks++;
        if (rd_data !== ref_mem[a + 9'(c - 2)]) begin
          errors++; $display("FAIL rd_data c=%0d: got %h expected %h", c, rd_data, ref_mem[a + 9'(c - 2)]);
        end
      end
      checks++;
      if (done !== (c == L + 1)) begin errors++; $display("FAIL rd_done c=%0d: got %b expected %b", c, done, (c == L + 1)); end
      if (rd_valid === 1'b1) beats++;
      tick();
    end
    checks++;
    if (beats != L) begin errors++; $display("FAIL rd_beat_count: got %0d expected %0d", beats, L); end
  endtask

  // Uses wpat (wr_valid per cycle), wdat (beat data) and ncyc (cycles in ST_WR).
  task automatic write_burst(input logic [8:0] a, input logic [3:0] lf);
    int beat;
    logic [8:0]  ea;
    logic [15:0] ed;
    beat = 0;
    req_valid = 1'b1; req_we = 1'b1; req_addr = a; req_len = lf;
    #4;
    checks++;
    if (req_ready !== 1'b1) begin errors++; $display("FAIL wr_req_ready: got %b expected 1", req_ready); end
    tick();
    req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_len = '0;
    for (int c = 0; c < ncyc; c++) begin
      wr_valid = wpat[c];
      wr_data  = wpat[c] ? wdat[beat] : 16'hDEAD;
      #4;
      ea = wpat[c] ? a + 9'(beat) : 9'd0;
      ed = wpat[c] ? wdat[beat] : 16'h0000;
      checks++;
      if (wr_ready !== 1'b1) begin errors++; $display("FAIL wr_ready c=%0d: got %b expected 1", c, wr_ready); end
      checks++;
      if (mem_write !== wpat[c]) begin errors++; $display("FAIL wr_mem_write c=%0d: got %b expected %b", c, mem_write, wpat[c]); end
      checks++;
      if (mem_addr !== ea) begin errors++; $display("FAIL wr_mem_addr c=%0d: got %h expected %h", c, mem_addr, ea); end
      checks++;
      if (mem_din !== ed) begin errors++; $display("FAIL wr_mem_din c=%0d: got %h expected %h", c, mem_din, ed); end
      checks++;
      if ((mem_read !== 1'b0) || (done !== 1'b0)) begin
        errors++; $display("FAIL wr_read_done c=%0d: got read=%b done=%b expected 0 0", c, mem_read, done);
      end
      tick();
      if (wpat[c]) beat++;
    end
    wr_valid = 1'b1; wr_data = 16'hDEAD;
    #4;
    checks++;
    if (done !== 1'b1) begin errors++; $display("FAIL wr_done: got %b expected 1", done); end
    checks++;
    if ((wr_ready !== 1'b0) || (mem_write !== 1'b0)) begin
      errors++; $display("FAIL wr_done_gating: got ready=%b write=%b expected 0 0", wr_ready, mem_write);
    end
    tick();
    wr_valid = 1'b0;
    #4;
    checks++;
    if ((done !== 1'b0) || (req_ready !== 1'b1)) begin
      errors++; $display("FAIL wr_after_done: got done=%b ready=%b expected 0 1", done, req_ready);
    end
    tick();
  endtask

  task automatic test_reset();
    rst_b = 1'b0; req_valid = 1'b1; req_we = 1'b0; req_addr = 9'h010; req_len = 4'd4;
    tick();
    tick();
    #4;
    checks++;
    if ((req_ready !== 1'b0) || (wr_ready !== 1'b0)) begin
      errors++; $display("FAIL reset_ready: got req=%b wr=%b expected 0 0", req_ready, wr_ready);
    end
    checks++;
    if ((mem_read !== 1'b0) || (mem_write !== 1'b0)) begin
      errors++; $display("FAIL reset_strobes: got read=%b write=%b expected 0 0", mem_read, mem_write);
    end
    req_valid = 1'b0; req_addr = '0; req_len = '0;
    tick();
    rst_b = 1'b1;
    #4;
    checks++;
    if (req_ready !== 1'b1) begin errors++; $display("FAIL reset_idle_ready: got %b expected 1", req_ready); end
    checks++;
    if ((done !== 1'b0) || (rd_valid !== 1'b0) || (rd_data !== 16'h0)) begin
      errors++; $display("FAIL reset_outputs: got done=%b rd_valid=%b rd_data=%h expected 0 0 0000", done, rd_valid, rd_data);
    end
    checks++;
    if ((mem_addr !== 9'h0) || (mem_din !== 16'h0)) begin
      errors++; $display("FAIL reset_mem_bus: got addr=%h din=%h expected 000 0000", mem_addr, mem_din);
    end
    tick();
  endtask

  task automatic test_read_burst();
    for (int i = 0; i < 4; i++) preload(9'h010 + 9'(i), 16'hA000 + 16'(i));
    read_burst(9'h010, 4'd4);
  endtask

  task automatic test_write_gaps();
    preload(9'h023, 16'h7777);
    wpat = 32'b1101;
    wdat[0] = 16'h1111; wdat[1] = 16'h2222; wdat[2] = 16'h3333;
    ncyc = 4;
    write_burst(9'h020, 4'd3);
    checks++;
    if ((mem[9'h020] !== 16'h1111) || (mem[9'h021] !== 16'h2222) || (mem[9'h022] !== 16'h3333)) begin
      errors++; $display("FAIL wr_gap_contents: got %h %h %h expected 1111 2222 3333", mem[9'h020], mem[9'h021], mem[9'h022]);
    end
    checks++;
    if (mem[9'h023] !== 16'h7777) begin errors++; $display("FAIL wr_gap_overrun: got %h expected 7777", mem[9'h023]); end
  endtask

  task automatic test_wrap();
    preload(9'h1FF, 16'h0000);
    preload(9'h000, 16'h0000);
    wpat = 32'b11;
    wdat[0] = 16'hBEEF; wdat[1] = 16'hCAFE;
    ncyc = 2;
    write_burst(9'h1FF, 4'd2);
    checks++;
    if ((mem[9'h1FF] !== 16'hBEEF) || (mem[9'h000] !== 16'hCAFE)) begin
      errors++; $display("FAIL wrap_write: got %h %h expected BEEF CAFE", mem[9'h1FF], mem[9'h000]);
    end
    ref_mem[9'h1FF] = 16'hBEEF;
    ref_mem[9'h000] = 16'hCAFE;
    read_burst(9'h1FF, 4'd2);
  endtask

  task automatic test_len0();
    for (int i = 0; i < 16; i++) preload(9'h100 + 9'(i), 16'h5000 + 16'(i * 3));
    read_burst(9'h100, 4'd0);
  endtask

  task automatic test_reset_mid_read();
    int bad;
    bad = 0;
    for (int i = 0; i < 8; i++) preload(9'h040 + 9'(i), 16'h4000 + 16'(i));
    req_valid = 1'b1; req_we = 1'b0; req_addr = 9'h040; req_len = 4'd8;
    tick();
    req_valid = 1'b0; req_addr = '0; req_len = '0;
    #4;
    checks++;
    if (mem_read !== 1'b1) begin errors++; $display("FAIL mid_rst_started: got %b expected 1", mem_read); end
    tick();
    rst_b = 1'b0;
    #4;
    checks++;
    if ((mem_read !== 1'b0) || (req_ready !== 1'b0)) begin
      errors++; $display("FAIL mid_rst_gating: got read=%b ready=%b expected 0 0", mem_read, req_ready);
    end
    tick();
    rst_b = 1'b1;
    #4;
    checks++;
    if ((rd_valid !== 1'b0) || (done !== 1'b0) || (mem_read !== 1'b0)) begin
      errors++; $display("FAIL mid_rst_outputs: got rd_valid=%b done=%b read=%b expected 0 0 0", rd_valid, done, mem_read);
    end
    checks++;
    if (req_ready !== 1'b1) begin errors++; $display("FAIL mid_rst_ready: got %b expected 1", req_ready); end
    for (int c = 0; c < 10; c++) begin
      tick();
      #4;
      if ((rd_valid !== 1'b0) || (done !== 1'b0) || (mem_read !== 1'b0)) bad++;
    end
    checks++;
    if (bad != 0) begin errors++; $display("FAIL mid_rst_quiet: got %0d active cycles expected 0", bad); end
    tick();
  endtask

  task automatic test_back_to_back();
    preload(9'h011, 16'hA001);
    read_burst(9'h010, 4'd1);
    read_burst(9'h011, 4'd1);
    #4;
    checks++;
    if ((req_ready !== 1'b1) || (mem_read !== 1'b0)) begin
      errors++; $display("FAIL b2b_idle: got ready=%b read=%b expected 1 0", req_ready, mem_read);
    end
    tick();
  endtask

  initial begin
    rst_b = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_len = '0;
    wr_valid = 1'b0; wr_data = '0;
    bd_we = 1'b0; bd_addr = '0; bd_data = '0;
    wpat = '0; ncyc = 0;
    for (int i = 0; i < 16; i++) wdat[i] = '0;
    for (int i = 0; i < 512; i++) ref_mem[i] = '0;
    test_reset();
    test_read_burst();
    test_write_gaps();
    test_wrap();
    test_len0();
    test_reset_mid_read();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
